// File: rtl/irom_arbiter.sv
// irom_arbiter: two-port read arbiter in front of a single combinational
// instruction ROM. Port 0 is instruction fetch, port 1 is data/debug.
// Grants are combinational, responses come back exactly one cycle later.
module irom_arbiter #(
  parameter int DATAWIDTH = 32,
  parameter int ADDRWIDTH = 14
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req0,
  input  logic                 req1,
  input  logic [DATAWIDTH-1:0] addr0,
  input  logic [DATAWIDTH-1:0] addr1,
  output logic                 gnt0,
  output logic                 gnt1,
  output logic                 rvalid0,
  output logic                 rvalid1,
  output logic [DATAWIDTH-1:0] rdata0,
  output logic [DATAWIDTH-1:0] rdata1,
  output logic                 rerr0,
  output logic                 rerr1,
  output logic                 rom_ena,
  output logic [ADDRWIDTH-1:0] rom_addr,
  input  logic [DATAWIDTH-1:0] rom_dout
);

  // last_gnt = 1 means port 1 was granted most recently
  logic                 last_gnt;
  logic [DATAWIDTH-1:0] sel_addr;
  logic                 sel_err;
  logic [DATAWIDTH-1:0] resp_data;

  // Round-robin grant; nothing is granted while reset is held low
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (rst_n) begin
      if (req0 && req1) begin
        gnt0 = last_gnt;
        gnt1 = !last_gnt;
      end else begin
        gnt0 = req0;
        gnt1 = req1;
      end
    end
  end

  // Steer the winning address to the ROM and classify it as good or errored
  always_comb begin
    sel_addr  = gnt1 ? addr1 : addr0;
    rom_ena   = gnt0 | gnt1;
    rom_addr  = rom_ena ? sel_addr[ADDRWIDTH+1:2] : '0;
    sel_err   = (sel_addr[1:0] != 2'b00) ||
                (sel_addr[DATAWIDTH-1:ADDRWIDTH+2] != '0);
    resp_data = sel_err ? '0 : rom_dout;
  end

  // Last-grant pointer only moves on a cycle that actually grants
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_gnt <= 1'b1;
    end else if (gnt0 || gnt1) begin
      last_gnt <= gnt1;
    end
  end

  // Port 0 response register: one-cycle pulse, data held between responses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid0 <= 1'b0;
      rerr0   <= 1'b0;
      rdata0  <= '0;
    end else begin
      rvalid0 <= gnt0;
      rerr0   <= gnt0 & sel_err;
      if (gnt0) begin
        rdata0 <= resp_data;
      end
    end
  end

  // Port 1 response register: one-cycle pulse, data held between responses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid1 <= 1'b0;
      rerr1   <= 1'b0;
      rdata1  <= '0;
    end else begin
      rvalid1 <= gnt1;
      rerr1   <= gnt1 & sel_err;
      if (gnt1) begin
        rdata1 <= resp_data;
      end
    end
  end

endmodule

// File: tb/tb_irom_arbiter.sv
// tb_irom_arbiter: directed bench for irom_arbiter with a cycle-level
// behavioural model checked on every falling edge, plus literal spot checks.
module tb_irom_arbiter;

  localparam int DW = 32;
  localparam int AW = 14;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req0, req1;
  logic [DW-1:0] addr0, addr1;
  logic          gnt0, gnt1, rvalid0, rvalid1, rerr0, rerr1, rom_ena;
  logic [DW-1:0] rdata0, rdata1, rom_dout;
  logic [AW-1:0] rom_addr;

  int n_cmp  = 0;
  int n_fail = 0;

  // ROM contents: word i holds 0xC0DE_0000 | i
  function automatic logic [DW-1:0] rom_word(input int idx);
    return 32'hC0DE_0000 | DW'(idx);
  endfunction

  assign rom_dout = rom_word(int'(rom_addr));

  always #5 clk = ~clk;

  irom_arbiter #(.DATAWIDTH(DW), .ADDRWIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1), .rerr0(rerr0), .rerr1(rerr1),
    .rom_ena(rom_ena), .rom_addr(rom_addr), .rom_dout(rom_dout)
  );

  task automatic checkOutput(input string name, input logic [DW-1:0] actual,
                             input logic [DW-1:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive one cycle's inputs just after the rising edge, then let them settle
  task automatic applyStimulus(input logic rst, input logic r0, input logic [DW-1:0] a0,
                               input logic r1, input logic [DW-1:0] a1);
    @(posedge clk);
    #1;
    rst_n = rst;
    req0  = r0;
    addr0 = a0;
    req1  = r1;
    addr1 = a1;
    #1;
  endtask

  // Model state: registered outputs the DUT must show, and who won last
  int            m_last = 1;
  logic          m_rv[2] = '{1'b0, 1'b0};
  logic          m_re[2] = '{1'b0, 1'b0};
  logic [DW-1:0] m_rd[2] = '{32'h0, 32'h0};

  // Reference model and per-cycle comparison
  always @(negedge clk) begin
    int            win;
    logic [DW-1:0] a;
    logic          bad;
    if (!rst_n) begin
      m_last = 1;
      m_rv   = '{1'b0, 1'b0};
      m_re   = '{1'b0, 1'b0};
      m_rd   = '{32'h0, 32'h0};
    end
    win = -1;
    if (rst_n) begin
      if (req0 && req1) win = (m_last == 0) ? 1 : 0;
      else if (req0)    win = 0;
      else if (req1)    win = 1;
    end
    a   = (win == 1) ? addr1 : addr0;
    bad = (a % 4 != 0) || (a >= 32'h0001_0000);

    checkOutput("m_gnt0",    DW'(gnt0),    DW'(win == 0));
    checkOutput("m_gnt1",    DW'(gnt1),    DW'(win == 1));
    checkOutput("m_excl",    DW'(gnt0 & gnt1), 32'h0);
    checkOutput("m_rom_ena", DW'(rom_ena), DW'(win >= 0));
    checkOutput("m_rom_addr", DW'(rom_addr), (win >= 0) ? (a / 4) % (1 << AW) : 32'h0);
    checkOutput("m_rvalid0", DW'(rvalid0), DW'(m_rv[0]));
    checkOutput("m_rvalid1", DW'(rvalid1), DW'(m_rv[1]));
    checkOutput("m_rdata0",  rdata0,       m_rd[0]);
    checkOutput("m_rdata1",  rdata1,       m_rd[1]);
    checkOutput("m_rerr0",   DW'(rerr0),   DW'(m_re[0]));
    checkOutput("m_rerr1",   DW'(rerr1),   DW'(m_re[1]));

    if (rst_n) begin
      m_rv = '{1'b0, 1'b0};
      m_re = '{1'b0, 1'b0};
      if (win >= 0) begin
        m_rv[win] = 1'b1;
        m_re[win] = bad;
        m_rd[win] = bad ? 32'h0 : rom_word(int'((a / 4) % (1 << AW)));
        m_last    = win;
      end
    end
  end

  // Directed scenarios with literal spot checks
  initial begin
    rst_n = 1'b0; req0 = 1'b1; addr0 = 32'h10; req1 = 1'b0; addr1 = 32'h0;

    // Requests during reset are ignored
    applyStimulus(0, 1, 32'h10, 0, 0);
    checkOutput("rst_gnt0",    DW'(gnt0),    32'h0);
    checkOutput("rst_rom_ena", DW'(rom_ena), 32'h0);
    checkOutput("rst_rvalid0", DW'(rvalid0), 32'h0);
    checkOutput("rst_rdata0",  rdata0,       32'h0);

    // Single fetch of word 4
    applyStimulus(1, 1, 32'h10, 0, 0);
    checkOutput("fetch_gnt0",     DW'(gnt0),     32'h1);
    checkOutput("fetch_rom_addr", DW'(rom_addr), 32'h4);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("fetch_rvalid0", DW'(rvalid0), 32'h1);
    checkOutput("fetch_rdata0",  rdata0,       32'hC0DE_0004);
    checkOutput("fetch_rerr0",   DW'(rerr0),   32'h0);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("fetch_rvalid0_off", DW'(rvalid0), 32'h0);
    checkOutput("fetch_rdata0_hold", rdata0,       32'hC0DE_0004);

    // Misaligned and out-of-range requests on port 1
    applyStimulus(1, 0, 0, 1, 32'h2);
    checkOutput("mis_gnt1",    DW'(gnt1),    32'h1);
    checkOutput("mis_rom_ena", DW'(rom_ena), 32'h1);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("mis_rvalid1", DW'(rvalid1), 32'h1);
    checkOutput("mis_rerr1",   DW'(rerr1),   32'h1);
    checkOutput("mis_rdata1",  rdata1,       32'h0);
    applyStimulus(1, 0, 0, 1, 32'h0001_0000);
    checkOutput("oor_gnt1", DW'(gnt1), 32'h1);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("oor_rvalid1", DW'(rvalid1), 32'h1);
    checkOutput("oor_rerr1",   DW'(rerr1),   32'h1);
    checkOutput("oor_rdata1",  rdata1,       32'h0);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("oor_rerr1_off", DW'(rerr1), 32'h0);

    // Streaming: eight back-to-back fetches from word 0x40 upward
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1, 1, 32'h100 + 32'(4 * i), 0, 0);
      checkOutput("stream_gnt0", DW'(gnt0), 32'h1);
      if (i > 0) begin
        checkOutput("stream_rvalid0", DW'(rvalid0), 32'h1);
        checkOutput("stream_rdata0",  rdata0,       32'hC0DE_0040 + 32'(i - 1));
      end
    end
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("stream_last_rdata0", rdata0, 32'hC0DE_0047);

    // Conflict after a fresh reset: 0,1,0,1
    applyStimulus(0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 1, 32'h20, 1, 32'h30);
      checkOutput("rr_gnt0", DW'(gnt0), DW'(i % 2 == 0));
      checkOutput("rr_gnt1", DW'(gnt1), DW'(i % 2 == 1));
    end
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("rr_last_rvalid1", DW'(rvalid1), 32'h1);
    checkOutput("rr_last_rdata1",  rdata1,       32'hC0DE_000C);

    // Losing requester withdraws: no response for it
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(1, 1, 32'h20, 1, 32'h30);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("wd_rvalid1", DW'(rvalid1), 32'h0);

    // Reset in the cycle after a port-1 grant kills the response
    applyStimulus(1, 0, 0, 1, 32'h40);
    checkOutput("mid_gnt1", DW'(gnt1), 32'h1);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("mid_rvalid1", DW'(rvalid1), 32'h0);
    applyStimulus(0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 0, 0, 0, 0);
      checkOutput("mid_post_rvalid1", DW'(rvalid1), 32'h0);
    end

    // Mixed traffic table, checked by the model only
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1, (i % 3) != 0, 32'(4 * i), (i % 2) == 0,
                    32'h3FFC - 32'(4 * i) + ((i == 5) ? 32'h1 : 32'h0));
    end
    repeat (3) applyStimulus(1, 0, 0, 0, 0);

    @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
